// File: rtl/fire7_expand3_core.sv
// fire7_expand3_core
//   Expand-3x3 MAC core for SqueezeNet fire7. A serial pixel stream is
//   multiplied by one weight word per output channel and accumulated in
//   DSP_NO parallel lanes. At the end of every KERNEL_DIM^2*CHIN pixel window
//   each lane adds its bias, applies ReLU and requantizes to Q2.14.
//
//   Ports
//     clk           single clock, rising edge
//     rst           synchronous, active-low reset
//     en_i          input pixel valid
//     ifm_i         input pixel, signed Q2.14
//     ram_feedback  downstream acknowledge of layer completion (sticky)
//     sample        one-cycle pulse, ofm holds a new window result
//     finish        layer done and not yet acknowledged
//     ofm           DSP_NO output activations
//
//   Pipeline: input register -> weight read and product -> accumulate
//   -> bias/ReLU/requant register. A result appears 3 cycles after the
//   edge that samples the last pixel of a window.
//
//   Weight and bias contents are parameter tables. WEIGHT_ROM holds one word
//   per pixel position, with lane i in bits [WIDTH*i +: WIDTH]. BIAS_ROM
//   holds one signed Q4.28 word per lane.
module fire7_expand3_core #(
    parameter int WOUT       = 16,
    parameter int DSP_NO     = 192,
    parameter int WIDTH      = 16,
    parameter int CHIN       = 64,
    parameter int KERNEL_DIM = 3,
    parameter logic [DSP_NO*WIDTH-1:0] WEIGHT_ROM [KERNEL_DIM*KERNEL_DIM*CHIN] = '{default: '0},
    parameter logic [2*WIDTH-1:0]      BIAS_ROM   [DSP_NO]                    = '{default: '0}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] ifm_i,
    input  logic             ram_feedback,
    output logic             sample,
    output logic             finish,
    output logic [WIDTH-1:0] ofm [0:DSP_NO-1]
);

    localparam int N    = KERNEL_DIM * KERNEL_DIM * CHIN;
    localparam int KW   = (N > 1) ? $clog2(N) : 1;
    localparam int NWIN = WOUT * WOUT;
    localparam int WCW  = $clog2(NWIN + 1);
    localparam int PW   = 2 * WIDTH;

    logic                    en1_q, en1_d;
    logic [WIDTH-1:0]        pix1_q, pix1_d;
    logic [KW-1:0]           k_q, k_d;
    logic                    val2_q, val2_d;
    logic                    last2_q, last2_d;
    logic signed [PW-1:0]    prod2_q [DSP_NO];
    logic signed [PW-1:0]    prod2_d [DSP_NO];
    logic                    clear_q, clear_d;
    logic                    close3_q, close3_d;
    logic signed [PW-1:0]    acc_q [DSP_NO];
    logic signed [PW-1:0]    acc_d [DSP_NO];
    logic [WIDTH-1:0]        ofm_q [DSP_NO];
    logic [WIDTH-1:0]        ofm_d [DSP_NO];
    logic                    sample_q, sample_d;
    // Windows still to be produced in this layer; end flag sets when it runs out.
    logic [WCW-1:0]          win_left_q, win_left_d;
    logic                    end_q, end_d;
    logic                    fb_q, fb_d;

    logic                    accept;
    logic [DSP_NO*WIDTH-1:0] w_row;
    logic signed [PW-1:0]    sum_s;

    always_comb begin
        en1_d      = en_i;
        pix1_d     = ifm_i;
        accept     = en1_q && !end_q;
        w_row      = WEIGHT_ROM[k_q];
        k_d        = k_q;
        val2_d     = accept;
        last2_d    = 1'b0;
        prod2_d    = prod2_q;
        clear_d    = clear_q;
        close3_d   = 1'b0;
        acc_d      = acc_q;
        ofm_d      = ofm_q;
        sample_d   = 1'b0;
        win_left_d = win_left_q;
        end_d      = end_q;
        fb_d       = fb_q | ram_feedback;
        sum_s      = '0;

        if (accept) begin
            last2_d = (k_q == KW'(N - 1));
            k_d     = last2_d ? '0 : k_q + KW'(1);
            for (int i = 0; i < DSP_NO; i++) begin
                prod2_d[i] = PW'($signed(pix1_q)) * PW'($signed(w_row[i*WIDTH +: WIDTH]));
            end
        end

        // The first product of a window replaces the previous window's sum
        // instead of adding to it, so back-to-back windows lose no cycle.
        if (val2_q && !end_q) begin
            for (int i = 0; i < DSP_NO; i++) begin
                acc_d[i] = (clear_q ? '0 : acc_q[i]) + prod2_q[i];
            end
            clear_d  = last2_q;
            close3_d = last2_q;
        end

        // Requant keeps S[2W-4:W-2] with a zero sign bit; negative sums clamp to 0.
        if (close3_q && !end_q) begin
            sample_d = 1'b1;
            for (int i = 0; i < DSP_NO; i++) begin
                sum_s    = acc_q[i] + $signed(BIAS_ROM[i]);
                ofm_d[i] = sum_s[PW-1] ? '0
                         : (WIDTH'(sum_s >> (WIDTH - 2)) & {1'b0, {(WIDTH-1){1'b1}}});
            end
        end

        if (sample_q) begin
            win_left_d = win_left_q - WCW'(1);
            if (win_left_q == WCW'(1)) begin
                end_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            en1_q      <= 1'b0;
            pix1_q     <= '0;
            k_q        <= '0;
            val2_q     <= 1'b0;
            last2_q    <= 1'b0;
            clear_q    <= 1'b0;
            close3_q   <= 1'b0;
            sample_q   <= 1'b0;
            win_left_q <= WCW'(NWIN);
            end_q      <= 1'b0;
            fb_q       <= 1'b0;
            for (int i = 0; i < DSP_NO; i++) begin
                prod2_q[i] <= '0;
                acc_q[i]   <= '0;
                ofm_q[i]   <= '0;
            end
        end else begin
            en1_q      <= en1_d;
            pix1_q     <= pix1_d;
            k_q        <= k_d;
            val2_q     <= val2_d;
            last2_q    <= last2_d;
            clear_q    <= clear_d;
            close3_q   <= close3_d;
            sample_q   <= sample_d;
            win_left_q <= win_left_d;
            end_q      <= end_d;
            fb_q       <= fb_d;
            prod2_q    <= prod2_d;
            acc_q      <= acc_d;
            ofm_q      <= ofm_d;
        end
    end

    assign sample = sample_q;
    assign finish = end_q & ~fb_q;
    assign ofm    = ofm_q;

endmodule

// File: tb/tb_fire7_expand3_core.sv
module tb_fire7_expand3_core;

    localparam int WOUT     = 2;
    localparam int DSP_NO   = 4;
    localparam int WIDTH    = 16;
    localparam int CHIN     = 1;
    localparam int KDIM     = 3;
    localparam int NWIN     = KDIM * KDIM * CHIN;
    localparam int NWINDOWS = WOUT * WOUT;

    localparam logic [15:0] LANE_WV [4] = '{16'h4000, 16'h4000, 16'h2000, 16'hE000};
    localparam logic [DSP_NO*WIDTH-1:0] TB_W [NWIN] = '{default: 64'hE000_2000_4000_4000};
    localparam logic [31:0] TB_B [DSP_NO] = '{32'h0000_0000, 32'h0010_0000, 32'hFFF0_0000, 32'h0020_0000};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_i = 1'b0;
    logic [15:0] ifm_i = '0;
    logic        ram_feedback = 1'b0;
    logic        sample;
    logic        finish;
    logic [15:0] ofm [0:DSP_NO-1];

    fire7_expand3_core #(
        .WOUT(WOUT), .DSP_NO(DSP_NO), .WIDTH(WIDTH), .CHIN(CHIN), .KERNEL_DIM(KDIM),
        .WEIGHT_ROM(TB_W), .BIAS_ROM(TB_B)
    ) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .ifm_i(ifm_i), .ram_feedback(ram_feedback),
        .sample(sample), .finish(finish), .ofm(ofm)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: collects results only, comparisons are made in the test tasks
    logic [63:0] got_q [$];
    int          got_cyc_q [$];
    int          samp_cnt = 0;
    int          dbl_cnt = 0;
    int          fin_cyc = -1;
    bit          fin_seen = 0;
    bit          prev_s = 0;

    always @(negedge clk) begin
        if (!rst) begin
            got_q.delete();
            got_cyc_q.delete();
            samp_cnt = 0;
            dbl_cnt  = 0;
            fin_cyc  = -1;
            fin_seen = 0;
            prev_s   = 0;
        end else begin
            if (sample) begin
                got_q.push_back({ofm[3], ofm[2], ofm[1], ofm[0]});
                got_cyc_q.push_back(cyc);
                samp_cnt++;
                if (prev_s) dbl_cnt++;
            end
            prev_s = sample;
            if (finish && fin_cyc < 0) fin_cyc = cyc;
            if (finish) fin_seen = 1;
        end
    end

    // scoreboard / reference model
    logic [63:0] exp_q [$];
    int          exp_cyc_q [$];
    logic [15:0] win_buf [NWIN];
    int          m_cnt = 0;
    int          m_wins = 0;
    bit          m_end = 0;
    int          got_rd = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [63:0] model_out();
        logic [63:0] r;
        longint      s;
        logic [31:0] s32;
        r = '0;
        for (int l = 0; l < DSP_NO; l++) begin
            s = longint'($signed(TB_B[l]));
            for (int j = 0; j < NWIN; j++)
                s += longint'($signed(win_buf[j])) * longint'($signed(LANE_WV[l]));
            s32 = s[31:0];
            r[l*16 +: 16] = s32[31] ? 16'h0000 : 16'((s32 >> 14) & 32'h7FFF);
        end
        return r;
    endfunction

    task automatic drive(input logic en, input logic [15:0] px);
        en_i  = en;
        ifm_i = px;
        @(posedge clk);
        #1;
        if (en && !m_end) begin
            win_buf[m_cnt] = px;
            m_cnt++;
            if (m_cnt == NWIN) begin
                exp_q.push_back(model_out());
                exp_cyc_q.push_back(cyc);
                m_cnt = 0;
                m_wins++;
                if (m_wins == NWINDOWS) m_end = 1;
            end
        end
        en_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_samples(input int n, input int budget);
        for (int c = 0; c < budget && samp_cnt < n; c++) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en_i = 1'b0;
        ram_feedback = 1'b0;
        idle(2);
        exp_q.delete();
        exp_cyc_q.delete();
        m_cnt = 0;
        m_wins = 0;
        m_end = 0;
        got_rd = 0;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (sample !== 1'b0) begin n_fail++; $display("FAIL reset_sample: got %b expected 0", sample); end
        n_checks++; if (finish !== 1'b0) begin n_fail++; $display("FAIL reset_finish: got %b expected 0", finish); end
        for (int i = 0; i < DSP_NO; i++) begin
            n_checks++;
            if (ofm[i] !== 16'h0) begin n_fail++; $display("FAIL reset_ofm[%0d]: got %h expected 0000", i, ofm[i]); end
        end
    endtask

    task automatic test_basic();
        logic [63:0] e, g; int ec, gc;
        do_reset();
        repeat (NWIN) drive(1'b1, 16'h0400);
        wait_samples(1, 20);
        idle(3);
        n_checks++; if (samp_cnt !== 1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", samp_cnt); end
        n_checks++; if (dbl_cnt !== 0) begin n_fail++; $display("FAIL basic_pulse_width: got %0d long pulses expected 0", dbl_cnt); end
        n_checks++; if (ofm[0] !== 16'h2400) begin n_fail++; $display("FAIL basic_lane0: got %h expected 2400", ofm[0]); end
        n_checks++; if (ofm[1] !== 16'h2440) begin n_fail++; $display("FAIL basic_lane1_bias: got %h expected 2440", ofm[1]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
            if (got_rd < got_q.size()) begin g = got_q[got_rd]; gc = got_cyc_q[got_rd]; got_rd++; end
            else begin g = 'x; gc = -1; end
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL basic_ofm: got %h expected %h", g, e); end
            n_checks++; if (gc - ec !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", gc - ec); end
        end
    endtask

    task automatic test_neg_then_pos();
        logic [63:0] e, g; int ec, gc;
        do_reset();
        repeat (NWIN) drive(1'b1, 16'hC000);
        repeat (NWIN) drive(1'b1, 16'h0400);
        wait_samples(2, 30);
        idle(2);
        n_checks++; if (samp_cnt !== 2) begin n_fail++; $display("FAIL neg_count: got %0d expected 2", samp_cnt); end
        n_checks++; if (ofm[0] !== 16'h2400) begin n_fail++; $display("FAIL neg_no_leak: got %h expected 2400", ofm[0]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
            if (got_rd < got_q.size()) begin g = got_q[got_rd]; gc = got_cyc_q[got_rd]; got_rd++; end
            else begin g = 'x; gc = -1; end
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL neg_ofm: got %h expected %h", g, e); end
            n_checks++; if (gc - ec !== 3) begin n_fail++; $display("FAIL neg_latency: got %0d expected 3", gc - ec); end
        end
    endtask

    task automatic test_gaps();
        logic [63:0] e, g; int ec, gc;
        do_reset();
        for (int p = 0; p < 2 * NWIN; p++) begin
            repeat ($urandom_range(0, 2)) drive(1'b0, 16'($urandom));
            drive(1'b1, 16'($urandom));
        end
        wait_samples(2, 30);
        idle(2);
        n_checks++; if (samp_cnt !== 2) begin n_fail++; $display("FAIL gaps_count: got %0d expected 2", samp_cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
            if (got_rd < got_q.size()) begin g = got_q[got_rd]; gc = got_cyc_q[got_rd]; got_rd++; end
            else begin g = 'x; gc = -1; end
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL gaps_ofm: got %h expected %h", g, e); end
            n_checks++; if (gc - ec !== 3) begin n_fail++; $display("FAIL gaps_latency: got %0d expected 3", gc - ec); end
        end
    endtask

    task automatic test_back_to_back_end();
        logic [63:0] e, g; int ec, gc;
        do_reset();
        repeat (NWINDOWS * NWIN + NWIN) drive(1'b1, 16'($urandom));
        wait_samples(NWINDOWS, 40);
        idle(20);
        n_checks++; if (samp_cnt !== NWINDOWS) begin n_fail++; $display("FAIL end_count: got %0d expected %0d", samp_cnt, NWINDOWS); end
        n_checks++; if (finish !== 1'b1) begin n_fail++; $display("FAIL end_finish: got %b expected 1", finish); end
        n_checks++;
        if (got_cyc_q.size() < NWINDOWS || fin_cyc - got_cyc_q[NWINDOWS-1] !== 1) begin
            n_fail++; $display("FAIL end_finish_timing: got finish at cycle %0d expected one after last sample", fin_cyc);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
            if (got_rd < got_q.size()) begin g = got_q[got_rd]; gc = got_cyc_q[got_rd]; got_rd++; end
            else begin g = 'x; gc = -1; end
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL end_ofm: got %h expected %h", g, e); end
            n_checks++; if (gc - ec !== 3) begin n_fail++; $display("FAIL end_latency: got %0d expected 3", gc - ec); end
        end
        ram_feedback = 1'b1;
        idle(1);
        ram_feedback = 1'b0;
        idle(1);
        n_checks++; if (finish !== 1'b0) begin n_fail++; $display("FAIL end_ack: got %b expected 0", finish); end
        repeat (NWIN) drive(1'b1, 16'h0400);
        idle(10);
        n_checks++; if (finish !== 1'b0) begin n_fail++; $display("FAIL end_ack_sticky: got %b expected 0", finish); end
        n_checks++; if (samp_cnt !== NWINDOWS) begin n_fail++; $display("FAIL end_no_extra: got %0d expected %0d", samp_cnt, NWINDOWS); end
    endtask

    task automatic test_early_feedback();
        do_reset();
        ram_feedback = 1'b1;
        idle(1);
        ram_feedback = 1'b0;
        repeat (NWINDOWS * NWIN) drive(1'b1, 16'($urandom));
        wait_samples(NWINDOWS, 40);
        idle(10);
        n_checks++; if (samp_cnt !== NWINDOWS) begin n_fail++; $display("FAIL early_fb_count: got %0d expected %0d", samp_cnt, NWINDOWS); end
        n_checks++; if (fin_seen !== 1'b0) begin n_fail++; $display("FAIL early_fb_finish: got %b expected 0", fin_seen); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] e, g; int ec, gc;
        do_reset();
        repeat (NWIN) drive(1'b1, 16'h0400);
        wait_samples(1, 20);
        idle(2);
        n_checks++; if (ofm[0] !== 16'h2400) begin n_fail++; $display("FAIL mid_prewindow: got %h expected 2400", ofm[0]); end
        repeat (5) drive(1'b1, 16'h7FFF);
        do_reset();
        n_checks++; if (sample !== 1'b0) begin n_fail++; $display("FAIL mid_reset_sample: got %b expected 0", sample); end
        for (int i = 0; i < DSP_NO; i++) begin
            n_checks++;
            if (ofm[i] !== 16'h0) begin n_fail++; $display("FAIL mid_reset_ofm[%0d]: got %h expected 0000", i, ofm[i]); end
        end
        repeat (NWIN) drive(1'b1, 16'h0400);
        wait_samples(1, 20);
        idle(2);
        n_checks++; if (ofm[0] !== 16'h2400) begin n_fail++; $display("FAIL mid_no_carry: got %h expected 2400", ofm[0]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
            if (got_rd < got_q.size()) begin g = got_q[got_rd]; gc = got_cyc_q[got_rd]; got_rd++; end
            else begin g = 'x; gc = -1; end
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL mid_ofm: got %h expected %h", g, e); end
            n_checks++; if (gc - ec !== 3) begin n_fail++; $display("FAIL mid_latency: got %0d expected 3", gc - ec); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg_then_pos();
        test_gaps();
        test_back_to_back_end();
        test_early_feedback();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
